// File: rtl/cpu_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes,
// NZCV bit positions and FlagW half-select masks.
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [1:0] FLAGW_NZ = 2'b10;
    localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition code against stored NZCV flags.
module cond_check
    import cpu_pkg::*;
#(
    parameter bit NV_EXECUTES = 1'b0
) (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v, ge;

    always_comb begin
        n  = Flags[FLAG_N];
        z  = Flags[FLAG_Z];
        c  = Flags[FLAG_C];
        v  = Flags[FLAG_V];
        ge = (n == v);
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = NV_EXECUTES;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, condition evaluation and
// gating of the decoder's PCS/RegW/MemW into the final write strobes.
module cond_logic
    import cpu_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST   = 4'b0000,
    parameter bit         NV_EXECUTES = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Stall,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       issue;

    assign Flags = {nz_q, cv_q};

    cond_check #(
        .NV_EXECUTES(NV_EXECUTES)
    ) u_cond_check (
        .Cond  (Cond),
        .Flags (Flags),
        .CondEx(CondEx)
    );

    assign issue    = CondEx & ~Stall & ~reset;
    assign PCSrc    = PCS  & issue;
    assign RegWrite = RegW & issue;
    assign MemWrite = MemW & issue;

    // Each half commits independently; an unselected half holds.
    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (issue && ((FlagW & FLAGW_NZ) != '0)) nz_d = ALUFlags[FLAG_N:FLAG_Z];
        if (issue && ((FlagW & FLAGW_CV) != '0)) cv_d = ALUFlags[FLAG_C:FLAG_V];
    end

    always_ff @(posedge clk) begin
        if (reset) nz_q <= FLAGS_RST[FLAG_N:FLAG_Z];
        else       nz_q <= nz_d;
    end

    always_ff @(posedge clk) begin
        if (reset) cv_q <= FLAGS_RST[FLAG_C:FLAG_V];
        else       cv_q <= cv_d;
    end

endmodule
